bank_isu_issue_sched: RTL and testbench
=======================================

Name: bank_isu_issue_sched

Overview:
- Per-bank issue scheduler that shares the single bank issue port among CHANNEL_NUM channels.
- Each channel presents its oldest valid, credit-allowed IQ entry. The block picks one channel per grant (round-robin with anti-starvation override) and holds the chosen entry on a valid/ready issue interface.
- On handshake it pulses a dequeue to the issue queue.
- Sits between the per-channel oldest-ready finders (downstream of credit management) and the bank read/write pipeline.

Parameters:
- CHANNEL_NUM, 3, number of channels (≤ 4; ch id is 2 bits)
- PTR_WIDTH, 8, IQ entry pointer width
- WAIT_WIDTH, 4, width of per-channel wait counters
- STARVE_LIMIT, 6, wait count at or above which a channel gets absolute priority

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ch_req_valid  input  CHANNEL_NUM  channel c has an issuable entry
- ch_req_ptr  input  CHANNEL_NUM*PTR_WIDTH  flattened; slice c = IQ pointer of channel c's candidate
- issue_valid  output  1  issue interface valid
- issue_ptr  output  PTR_WIDTH  IQ pointer being issued
- issue_ch_id  output  2  channel of the issued entry
- issue_ready  input  1  downstream accepts
- iq_dequeue  output  1  entry at iq_dequeue_ptr leaves the IQ this cycle
- iq_dequeue_ptr  output  PTR_WIDTH  equals issue_ptr
- flush  input  1  drop held issue, clear scheduler state
- sched_busy  output  1  issue_valid or any ch_req_valid

Behaviour:
- Reset values: issue_valid=0, issue_ptr=0, issue_ch_id=0, iq_dequeue=0, rr_ptr=0, all wait counters 0, state IDLE.
- Handshake: hs = issue_valid & issue_ready & ~flush.
  - iq_dequeue = hs, combinational. iq_dequeue_ptr = issue_ptr.
- Eligible mask: ch_req_valid, with two channels removed:
  - the channel currently held in HOLD without hs (its entry is already captured);
  - the channel being dequeued this cycle when hs=1 (its request still shows the leaving entry).
  - Consequence: a single channel alone issues at most 1 entry per 2 cycles; alternating channels reach 1 per cycle.
- Grant selection (combinational):
  - If any eligible channel has wait ≥ STARVE_LIMIT, grant the lowest-index such channel.
  - Otherwise round-robin: the first eligible channel searching from rr_ptr upward, wrapping modulo CHANNEL_NUM.
- Load condition: (state==IDLE | hs) & any eligible & ~flush.
  - Next cycle: issue_valid=1, issue_ptr=granted ptr, issue_ch_id=granted ch, rr_ptr=(granted+1) mod CHANNEL_NUM.
  - Latency: request at cycle N → issue_valid at N+1 (registered output, no bypass).
- FSM:
  - IDLE: load → HOLD; else stay in IDLE.
  - HOLD:
    - ~issue_ready → stay in HOLD; issue_ptr and issue_ch_id stable (valid must not drop).
    - hs & load → HOLD with new entry (back-to-back).
    - hs & no eligible → IDLE, issue_valid=0.
- Wait counters, per channel c, updated on every clock:
  - granted on load → 0;
  - ch_req_valid[c]=0 → 0;
  - otherwise, when a load to another channel occurs or the channel was masked, increment, saturating at 2^WAIT_WIDTH−1.
- flush: highest priority, overrides a simultaneous handshake.
  - iq_dequeue=0 in that cycle.
  - Next cycle: state IDLE, issue_valid=0, wait counters 0, rr_ptr unchanged.
  - No load occurs in the flush cycle.
- Reset mid-HOLD: issue_valid drops immediately (asynchronous); no dequeue is generated.
- ch_req_ptr of a non-eligible channel is ignored. The captured pointer is not re-checked against the IQ while held; the IQ guarantees the entry persists until dequeue.

Decomposition:
- Shared package bank_isu_pkg: CHANNEL_NUM, PTR_WIDTH, ch id width (2), sched state enum {IDLE, HOLD}.
- One sub-module: bank_isu_rr_arb (CHANNEL_NUM-wide masked round-robin arbiter; inputs request mask and rr_ptr; outputs one-hot grant and any). The starvation override and FSM stay in the top.

Test Plan:
- Single request: ch1 valid, ptr=0x23, issue_ready=1 from cycle 0 → issue_valid at cycle 1 with ptr 0x23, ch 1; iq_dequeue=1 at cycle 1; cycle 2 has issue_valid=0 (ch1 masked); reissue at cycle 3 if still requesting.
- Round-robin fairness: all 3 channels valid continuously (ptrs 0x10/0x20/0x30), ready=1 → grants ch0, ch1, ch2, ch0 … one per cycle, no gaps.
- Backpressure: issue_ready=0 for 5 cycles while in HOLD with ch2/ptr 0x44 → issue_ptr and issue_ch_id stable, iq_dequeue=0; ready=1 → exactly one dequeue of 0x44.
- Starvation: hold ch0's wait counter at 6 (force ch0 ineligible via masking sequence while ch1/ch2 alternate), then make rr_ptr favour ch1 → ch0 granted next despite rr_ptr, and its counter clears.
- Flush vs handshake: flush=1 and issue_ready=1 in the same cycle with ptr 0x55 held → iq_dequeue=0; issue_valid=0 next cycle; rr_ptr unchanged.
- Async reset in HOLD: assert rst mid-cycle → issue_valid=0 immediately; after release, rr_ptr=0 and ch0 wins a 3-way tie.

Source files
------------

// File: rtl/bank_isu_pkg.sv
// Shared types and sizes for the per-bank issue scheduler.
package bank_isu_pkg;
  localparam int unsigned CHANNEL_NUM = 3;
  localparam int unsigned PTR_WIDTH   = 8;
  localparam int unsigned CH_ID_WIDTH = 2;

  typedef enum logic [0:0] {StIdle, StHold} sched_state_e;
endpackage

// File: rtl/bank_isu_rr_arb.sv
// Masked round-robin arbiter: first requester at or after rr_ptr, wrapping modulo N.
module bank_isu_rr_arb
  import bank_isu_pkg::*;
#(
  parameter int unsigned N = CHANNEL_NUM
) (
  input  logic [N-1:0]           req,
  input  logic [CH_ID_WIDTH-1:0] rr_ptr,
  output logic [N-1:0]           gnt,
  output logic                   any
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (!found && req[c] && (c == (32'(rr_ptr) + k) % N)) begin
          gnt[c] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/bank_isu_issue_sched.sv
// Shares one bank issue port among channels: round-robin with a starvation override,
// holding the chosen IQ entry on a valid/ready interface and pulsing dequeue on handshake.
module bank_isu_issue_sched
  import bank_isu_pkg::*;
#(
  parameter int unsigned WAIT_WIDTH   = 4,
  parameter int unsigned STARVE_LIMIT = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNEL_NUM-1:0]         ch_req_valid,
  input  logic [CHANNEL_NUM*PTR_WIDTH-1:0] ch_req_ptr,
  output logic                           issue_valid,
  output logic [PTR_WIDTH-1:0]           issue_ptr,
  output logic [CH_ID_WIDTH-1:0]         issue_ch_id,
  input  logic                           issue_ready,
  output logic                           iq_dequeue,
  output logic [PTR_WIDTH-1:0]           iq_dequeue_ptr,
  input  logic                           flush,
  output logic                           sched_busy
);

  localparam logic [WAIT_WIDTH-1:0] StarveLim = WAIT_WIDTH'(STARVE_LIMIT);
  localparam logic [WAIT_WIDTH-1:0] WaitMax   = '1;

  sched_state_e           state;
  logic [CH_ID_WIDTH-1:0] rr_ptr, rr_next, gnt_id;
  logic [WAIT_WIDTH-1:0]  wait_cnt [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] held_mask, elig, rr_gnt, gnt;
  logic [PTR_WIDTH-1:0]   gnt_ptr;
  logic                   hs, any_elig, starve_hit, load;

  assign hs             = issue_valid & issue_ready & ~flush;
  assign iq_dequeue     = hs;
  assign iq_dequeue_ptr = issue_ptr;
  assign sched_busy     = issue_valid | (|ch_req_valid);

  // The held channel is masked whether or not it is leaving: its request still shows that entry.
  always_comb begin
    held_mask = '0;
    for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
      if (issue_valid && (issue_ch_id == CH_ID_WIDTH'(c))) held_mask[c] = 1'b1;
    end
    elig = ch_req_valid & ~held_mask;
  end

  bank_isu_rr_arb #(
    .N(CHANNEL_NUM)
  ) u_rr_arb (
    .req    (elig),
    .rr_ptr (rr_ptr),
    .gnt    (rr_gnt),
    .any    (any_elig)
  );

  always_comb begin
    gnt        = rr_gnt;
    starve_hit = 1'b0;
    for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
      if (!starve_hit && elig[c] && (wait_cnt[c] >= StarveLim)) begin
        gnt        = '0;
        gnt[c]     = 1'b1;
        starve_hit = 1'b1;
      end
    end
    gnt_id  = '0;
    gnt_ptr = '0;
    rr_next = '0;
    for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
      if (gnt[c]) begin
        gnt_id  = CH_ID_WIDTH'(c);
        gnt_ptr = ch_req_ptr[c*PTR_WIDTH +: PTR_WIDTH];
        rr_next = (c == CHANNEL_NUM - 1) ? '0 : CH_ID_WIDTH'(c + 1);
      end
    end
  end

  assign load = ((state == StIdle) | hs) & any_elig & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      issue_valid <= 1'b0;
      issue_ptr   <= '0;
      issue_ch_id <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      state       <= StIdle;
      issue_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StHold: begin
          if (load) begin
            state       <= StHold;
            issue_valid <= 1'b1;
            issue_ptr   <= gnt_ptr;
            issue_ch_id <= gnt_id;
            rr_ptr      <= rr_next;
          end else if (hs) begin
            state       <= StIdle;
            issue_valid <= 1'b0;
          end
        end
        default: begin
          state       <= StIdle;
          issue_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNEL_NUM; c++) wait_cnt[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
        if (flush || !ch_req_valid[c] || (load && gnt[c])) begin
          wait_cnt[c] <= '0;
        end else if ((load || held_mask[c]) && (wait_cnt[c] != WaitMax)) begin
          wait_cnt[c] <= wait_cnt[c] + WAIT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_isu_issue_sched.sv
// Directed scenarios plus random traffic, checked against a cycle-level reference model.
module tb_bank_isu_issue_sched;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ch_req_valid;
  logic [N*8-1:0] ch_req_ptr;
  logic          issue_valid;
  logic [7:0]    issue_ptr;
  logic [1:0]    issue_ch_id;
  logic          issue_ready;
  logic          iq_dequeue;
  logic [7:0]    iq_dequeue_ptr;
  logic          flush;
  logic          sched_busy;

  int n_pass = 0, n_total = 0, n_fail = 0;

  // Reference model state
  bit       m_valid;
  bit [7:0] m_ptr;
  int       m_ch, m_rr;
  int       m_wait [N];

  bank_isu_issue_sched dut (
    .clk            (clk),
    .rst            (rst),
    .ch_req_valid   (ch_req_valid),
    .ch_req_ptr     (ch_req_ptr),
    .issue_valid    (issue_valid),
    .issue_ptr      (issue_ptr),
    .issue_ch_id    (issue_ch_id),
    .issue_ready    (issue_ready),
    .iq_dequeue     (iq_dequeue),
    .iq_dequeue_ptr (iq_dequeue_ptr),
    .flush          (flush),
    .sched_busy     (sched_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ptr = 0; m_ch = 0; m_rr = 0;
    for (int c = 0; c < N; c++) m_wait[c] = 0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [N-1:0] v, input logic [N*8-1:0] p, input bit rdy, input bit fl);
    bit hs, load;
    bit el [N];
    int g, c;
    check("issue_valid", issue_valid, m_valid);
    check("issue_ptr", issue_ptr, m_ptr);
    check("issue_ch_id", issue_ch_id, m_ch);
    ch_req_valid = v; ch_req_ptr = p; issue_ready = rdy; flush = fl;
    #1;
    hs = m_valid && rdy && !fl;
    check("iq_dequeue", iq_dequeue, hs);
    check("iq_dequeue_ptr", iq_dequeue_ptr, m_ptr);
    check("sched_busy", sched_busy, m_valid || (v != 0));
    g = -1;
    for (int i = 0; i < N; i++) el[i] = v[i] && !(m_valid && m_ch == i);
    for (int i = 0; i < N; i++) if (g < 0 && el[i] && m_wait[i] >= 6) g = i;
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (g < 0 && el[c]) g = c;
    end
    load = (!m_valid || hs) && (g >= 0) && !fl;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (fl || !v[i] || (load && g == i)) m_wait[i] = 0;
      else if ((load || (m_valid && m_ch == i)) && m_wait[i] < 15) m_wait[i]++;
    end
    if (fl) m_valid = 0;
    else if (load) begin
      m_valid = 1; m_ch = g; m_ptr = p[g*8 +: 8]; m_rr = (g + 1) % N;
    end else if (hs) m_valid = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    ch_req_valid = '0; ch_req_ptr = '0; issue_ready = 0; flush = 0;
    rst = 1;
    #1;
    model_reset();
    check("reset_valid", issue_valid, 0);
    check("reset_ptr", issue_ptr, 0);
    check("reset_ch", issue_ch_id, 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [N-1:0]   rv;
    logic [N*8-1:0] rp;
    rst = 1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single channel: issue, masked gap, reissue
    step(3'b010, 24'h002300, 1, 0);
    check("single_valid", issue_valid, 1);
    check("single_ptr", issue_ptr, 8'h23);
    check("single_ch", issue_ch_id, 1);
    step(3'b010, 24'h002300, 1, 0);
    check("single_gap", issue_valid, 0);
    step(3'b010, 24'h002300, 1, 0);
    check("single_reissue", issue_valid, 1);
    step(3'b000, 24'h0, 1, 0);

    // Round-robin with all three channels
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 24'h302010, 1, 0);
      check("rr_order", issue_ch_id, i % N);
    end

    // Backpressure holds the entry stable
    do_reset();
    step(3'b100, 24'h440000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(3'b100, 24'h440000, 0, 0);
      check("bp_ptr", issue_ptr, 8'h44);
      check("bp_ch", issue_ch_id, 2);
    end
    step(3'b000, 24'h0, 1, 0);
    check("bp_done", issue_valid, 0);

    // Starvation: ch0 held under backpressure builds wait, then beats rr_ptr
    do_reset();
    step(3'b111, 24'h302010, 0, 0);
    for (int i = 0; i < 7; i++) step(3'b111, 24'h302010, 0, 0);
    step(3'b111, 24'h302010, 1, 0);
    check("starve_rr", issue_ch_id, 1);
    step(3'b111, 24'h302010, 1, 0);
    check("starve_win", issue_ch_id, 0);

    // Flush beats a simultaneous handshake
    do_reset();
    step(3'b001, 24'h000055, 0, 0);
    step(3'b001, 24'h000055, 1, 1);
    check("flush_valid", issue_valid, 0);
    step(3'b111, 24'h302010, 1, 0);
    check("flush_rr_kept", issue_ch_id, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rv = N'($urandom_range(0, 7));
      rp = 24'($urandom);
      step(rv, rp, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    // Asynchronous reset while holding
    do_reset();
    step(3'b001, 24'h000011, 0, 0);
    issue_ready = 1;
    #2 rst = 1;
    #1;
    check("async_valid", issue_valid, 0);
    check("async_deq", iq_dequeue, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    step(3'b111, 24'h302010, 1, 0);
    check("async_tie_ch", issue_ch_id, 0);
    step(3'b000, 24'h0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
